// File: rtl/binary_counter_part_param_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : binary_counter_part_param_if                                 |
// | Description : Control and status bundle for the parametrised counter.      |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
interface binary_counter_part_param_if #(
  parameter int SIZE = 4
);
  logic            enable;
  logic            up_dn;
  logic            load;
  logic [SIZE-1:0] data_in;
  logic            clear;
  logic [SIZE-1:0] count;
  logic            tc;
  logic            wrap;
  logic            sat;
  logic            busy;

  modport master (
    output enable, up_dn, load, data_in, clear,
    input  count, tc, wrap, sat, busy
  );

  modport slave (
    input  enable, up_dn, load, data_in, clear,
    output count, tc, wrap, sat, busy
  );
endinterface
`default_nettype wire

// File: rtl/binary_counter_part_param.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : binary_counter_part_param                                    |
// | Description : Up/down modulo counter split into control FSM and datapath,  |
// |               with load/clear and wrap-or-saturate boundary handling.      |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module binary_counter_part_param #(
  parameter int SIZE     = 4,
  parameter int MODULUS  = 16,
  parameter bit SATURATE = 1'b0
) (
  input  wire                          clk,
  input  wire                          rst,
  binary_counter_part_param_if.slave   bus
);

  localparam logic [SIZE-1:0] c_max     = SIZE'(MODULUS - 1);
  localparam logic [SIZE-1:0] c_zero    = '0;
  localparam logic [SIZE-1:0] c_one     = SIZE'(1);
  localparam logic [SIZE:0]   c_mod_ext = (SIZE+1)'(MODULUS);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_SAT  = 2'd2
  } state_t;

  state_t          r_state;
  logic            r_busy;
  logic            r_sat;
  logic [SIZE-1:0] r_count;
  logic            r_wrap;

  // control-unit outputs towards the datapath
  logic            w_clr;
  logic            w_ld;
  logic            w_step;
  logic            w_dir;

  // datapath status towards the control unit
  logic            w_at_max;
  logic            w_at_zero;
  logic            w_bound;
  logic            w_sat_hit;
  logic            w_wrap_hit;
  logic [SIZE-1:0] w_ld_val;

  // ---------------------------------------------------------------- control
  assign w_clr  = bus.clear;
  assign w_ld   = !bus.clear && bus.load;
  assign w_step = !bus.clear && !bus.load && bus.enable && (r_state != S_SAT);
  assign w_dir  = bus.up_dn;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_busy  <= 1'b0;
      r_sat   <= 1'b0;
    end else if (w_clr || w_ld) begin
      r_state <= S_IDLE;
      r_busy  <= 1'b0;
      r_sat   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_RUN: begin
          if (bus.enable && w_sat_hit) begin
            r_state <= S_SAT;
            r_busy  <= 1'b0;
            r_sat   <= 1'b1;
          end else if (bus.enable) begin
            r_state <= S_RUN;
            r_busy  <= 1'b1;
            r_sat   <= 1'b0;
          end else begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_sat   <= 1'b0;
          end
        end
        S_SAT: begin
          r_state <= S_SAT;
          r_busy  <= 1'b0;
          r_sat   <= 1'b1;
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_sat   <= 1'b0;
        end
      endcase
    end
  end

  // --------------------------------------------------------------- datapath
  assign w_at_max  = (r_count == c_max);
  assign w_at_zero = (r_count == c_zero);
  assign w_bound   = w_dir ? w_at_max : w_at_zero;
  // data_in is widened by one bit so MODULUS = 2**SIZE still compares correctly
  assign w_ld_val  = ({1'b0, bus.data_in} >= c_mod_ext) ? c_max : bus.data_in;

  generate
    if (SATURATE) begin : g_saturate
      assign w_sat_hit  = w_step && w_bound;
      assign w_wrap_hit = 1'b0;
    end else begin : g_wrap
      assign w_sat_hit  = 1'b0;
      assign w_wrap_hit = w_step && w_bound;
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
      r_wrap  <= 1'b0;
    end else begin
      r_wrap <= 1'b0;
      if (w_clr) begin
        r_count <= '0;
      end else if (w_ld) begin
        r_count <= w_ld_val;
      end else if (w_wrap_hit) begin
        r_count <= w_dir ? c_zero : c_max;
        r_wrap  <= 1'b1;
      end else if (w_step && !w_bound) begin
        r_count <= w_dir ? (r_count + c_one) : (r_count - c_one);
      end
    end
  end

  assign bus.count = r_count;
  assign bus.wrap  = r_wrap;
  assign bus.sat   = r_sat;
  assign bus.busy  = r_busy;
  assign bus.tc    = (bus.up_dn && w_at_max) || (!bus.up_dn && w_at_zero);

endmodule
`default_nettype wire

// File: tb/tb_binary_counter_part_param.sv
`default_nettype none
// Scoreboarded bench: one wrapping and one saturating counter (modulus 10) share
// the same stimulus and are checked against an arithmetic reference model.
module tb_binary_counter_part_param;

  localparam int SIZE = 4;
  localparam int MOD  = 10;

  typedef struct {
    int cnt;
    bit wrap;
    bit sat;
    bit busy;
  } mstate_t;

  typedef struct {
    int cnt;
    bit wrap;
    bit sat;
    bit busy;
    bit tc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en = 1'b0, ud = 1'b1, ld = 1'b0, cl = 1'b0;
  logic [SIZE-1:0] din = '0;

  int checks = 0;
  int failures = 0;

  mstate_t mw, ms;
  exp_t qw[$];
  exp_t qs[$];

  binary_counter_part_param_if #(.SIZE(SIZE)) bw ();
  binary_counter_part_param_if #(.SIZE(SIZE)) bs ();

  assign bw.enable = en;  assign bs.enable = en;
  assign bw.up_dn = ud;   assign bs.up_dn = ud;
  assign bw.load = ld;    assign bs.load = ld;
  assign bw.data_in = din; assign bs.data_in = din;
  assign bw.clear = cl;   assign bs.clear = cl;

  binary_counter_part_param #(.SIZE(SIZE), .MODULUS(MOD), .SATURATE(1'b0)) dut_w (
    .clk(clk), .rst(rst), .bus(bw.slave)
  );
  binary_counter_part_param #(.SIZE(SIZE), .MODULUS(MOD), .SATURATE(1'b1)) dut_s (
    .clk(clk), .rst(rst), .bus(bs.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s: actual=%0d required=%0d at %0t", name, act, req, $time);
    end
  endtask

  // Reference behaviour: modular arithmetic on an integer count.
  function automatic void mstep(inout mstate_t m, input bit satm, input bit e,
                                input bit u, input bit l, input bit c, input int d);
    m.wrap = 1'b0;
    if (c) begin
      m.cnt = 0; m.sat = 0; m.busy = 0;
    end else if (l) begin
      m.cnt = (d < MOD) ? d : MOD - 1; m.sat = 0; m.busy = 0;
    end else if (m.sat) begin
      m.busy = 0;
    end else if (e) begin
      int nxt;
      nxt = u ? m.cnt + 1 : m.cnt - 1;
      if (nxt >= 0 && nxt < MOD) begin
        m.cnt = nxt; m.busy = 1;
      end else if (satm) begin
        m.sat = 1; m.busy = 0;
      end else begin
        m.cnt = (nxt + MOD) % MOD; m.wrap = 1; m.busy = 1;
      end
    end else begin
      m.busy = 0;
    end
  endfunction

  function automatic exp_t mkexp(input mstate_t m, input bit u);
    exp_t x;
    x.cnt = m.cnt; x.wrap = m.wrap; x.sat = m.sat; x.busy = m.busy;
    x.tc = u ? (m.cnt == MOD - 1) : (m.cnt == 0);
    return x;
  endfunction

  task automatic apply(input bit e, input bit u, input bit l, input bit c, input int d);
    en = e; ud = u; ld = l; cl = c; din = SIZE'(d);
    mstep(mw, 1'b0, e, u, l, c, d);
    mstep(ms, 1'b1, e, u, l, c, d);
    qw.push_back(mkexp(mw, u));
    qs.push_back(mkexp(ms, u));
  endtask

  task automatic cyc(input bit e, input bit u, input bit l, input bit c, input int d);
    @(posedge clk);
    #2;
    apply(e, u, l, c, d);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_w_count"}, int'(bw.count), 0);
    chk({tag, "_w_wrap"}, int'(bw.wrap), 0);
    chk({tag, "_w_sat"}, int'(bw.sat), 0);
    chk({tag, "_w_busy"}, int'(bw.busy), 0);
    chk({tag, "_w_tc"}, int'(bw.tc), int'(!ud));
    chk({tag, "_s_count"}, int'(bs.count), 0);
    chk({tag, "_s_sat"}, int'(bs.sat), 0);
    chk({tag, "_s_busy"}, int'(bs.busy), 0);
  endtask

  task automatic reset_mid_cycle();
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check_reset_outputs("async_rst");
    @(posedge clk);
    #2;
    check_reset_outputs("rst_held");
    mw = '{0, 0, 0, 0};
    ms = '{0, 0, 0, 0};
    rst = 1'b0;
    apply(1'b0, 1'b1, 1'b0, 1'b0, 0);
  endtask

  // Monitor: every clock edge is an output beat; compare against queued expectations.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (qw.size() > 0) begin
        exp_t x;
        x = qw.pop_front();
        chk("w_count", int'(bw.count), x.cnt);
        chk("w_wrap", int'(bw.wrap), int'(x.wrap));
        chk("w_sat", int'(bw.sat), int'(x.sat));
        chk("w_busy", int'(bw.busy), int'(x.busy));
        chk("w_tc", int'(bw.tc), int'(x.tc));
      end
      if (qs.size() > 0) begin
        exp_t x;
        x = qs.pop_front();
        chk("s_count", int'(bs.count), x.cnt);
        chk("s_wrap", int'(bs.wrap), int'(x.wrap));
        chk("s_sat", int'(bs.sat), int'(x.sat));
        chk("s_busy", int'(bs.busy), int'(x.busy));
        chk("s_tc", int'(bs.tc), int'(x.tc));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    mw = '{0, 0, 0, 0};
    ms = '{0, 0, 0, 0};
    #3;
    check_reset_outputs("reset");
    @(posedge clk);
    #2;
    rst = 1'b0;
    apply(1'b0, 1'b1, 1'b0, 1'b0, 0);

    // up wrap through 9 -> 0; the saturating copy sticks at 9
    repeat (12) cyc(1'b1, 1'b1, 1'b0, 1'b0, 0);
    // down wrap from 2
    repeat (4) cyc(1'b1, 1'b0, 1'b0, 1'b0, 0);
    // load clamp and priority
    cyc(1'b0, 1'b1, 1'b1, 1'b0, 12);
    cyc(1'b1, 1'b1, 1'b1, 1'b0, 3);
    cyc(1'b0, 1'b1, 1'b1, 1'b1, 5);
    // saturate from 7, then try to move it
    cyc(1'b0, 1'b1, 1'b1, 1'b0, 7);
    repeat (4) cyc(1'b1, 1'b1, 1'b0, 1'b0, 0);
    repeat (4) cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0, 1'b0, 0);
    cyc(1'b0, 1'b1, 1'b0, 1'b1, 0);
    // enable gating at 5
    repeat (5) cyc(1'b1, 1'b1, 1'b0, 1'b0, 0);
    repeat (3) cyc(1'b0, 1'b1, 1'b0, 1'b0, 0);
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 0);
    // asynchronous reset while running at 6
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 0);
    reset_mid_cycle();
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 0);

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      cyc(1'($urandom_range(0, 99) < 75), 1'($urandom_range(0, 1)),
          1'($urandom_range(0, 99) < 6), 1'($urandom_range(0, 99) < 4),
          int'($urandom_range(0, 15)));
    end
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 0);

    @(posedge clk);
    #3;
    chk("queue_w_drained", qw.size(), 0);
    chk("queue_s_drained", qs.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
